// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT byte FIFO behind the UART receiver with overflow and idle flags
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int IDLE_CYCLES = 640,
    parameter int IDLE_W      = 10
) (
    input  logic              baud_clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_status,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    input  logic              ovf_clear,
    output logic              idle
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              status_d;
    logic [IDLE_W-1:0] idle_cnt;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              ovf_set;

    // A byte arrives once per rising edge of the frame-done level; a full FIFO
    // still accepts it when the consumer frees a slot in the same cycle.
    assign push     = rx_status & ~status_d;
    assign full     = (count == FULL_COUNT);
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    assign wr_en    = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;

    assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;
    assign idle       = (idle_cnt == IDLE_MAX) & rd_valid;

    // Occupancy after this edge; drives both the count register and idle clearing.
    always_comb begin
        count_next = count;
        case ({wr_en, pop})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge baud_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Edge detector, pointers and occupancy. status_d resets high so a level
    // already asserted when reset releases is not taken as a new byte.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            status_d <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            status_d <= rx_status;
            count    <= count_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky overflow; a new drop takes priority over a clear request.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    // Cycles since the last byte arrived, saturating; held at zero while empty.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (push || (count_next == '0)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_ONE;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int IDLE  = 640;

    logic       baud_clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_status;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       ovf_clear;
    logic       idle;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_q[$];
    logic       m_status_d;
    logic       m_ovf;
    int         m_age;

    uart_rx_fifo dut (
        .baud_clk   (baud_clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_status  (rx_status),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear),
        .idle       (idle)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic model_reset();
        m_q.delete();
        m_status_d = 1'b1;
        m_ovf      = 1'b0;
        m_age      = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied, then
    // let the DUT take the same edge and settle.
    task automatic tick();
        bit p;
        bit dropped;
        if (!reset) begin
            model_reset();
        end else begin
            p          = rx_status && !m_status_d;
            m_status_d = rx_status;
            dropped    = 1'b0;
            if (rd_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (p) begin
                if (m_q.size() < DEPTH) m_q.push_back(rx_data);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (ovf_clear) m_ovf = 1'b0;
            if (p || m_q.size() == 0) m_age = 0;
            else if (m_age < IDLE) m_age = m_age + 1;
        end
        @(posedge baud_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_status = 1'b0;
        tick();
        rx_data   = b;
        rx_status = 1'b1;
        tick();
        rx_status = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_status = 1'b1; rx_data = 8'h5A; rd_ready = 1'b0; ovf_clear = 1'b0;
        model_reset();
        #12;
        n_cmp++;
        if (fifo_count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || idle !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: count=%0d valid=%b ovf=%b idle=%b, expected 0/0/0/0",
                     fifo_count, rd_valid, overflow, idle);
        end
        @(posedge baud_clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++;
            if (fifo_count !== 5'd0 || rd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_high_status cyc %0d: count=%0d valid=%b, expected 0/0", i, fifo_count, rd_valid);
            end
        end
    endtask

    task automatic test_edge_hold();
        rx_status = 1'b0;
        tick();
        rx_data   = 8'hA5;
        rx_status = 1'b1;
        tick();
        n_cmp++;
        if (fifo_count !== 5'd1 || rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
            n_err++;
            $display("FAIL edge_push: count=%0d valid=%b data=%h, expected 1/1/a5", fifo_count, rd_valid, rd_data);
        end
        for (int i = 0; i < 120; i++) begin
            tick();
            n_cmp++;
            if (fifo_count !== 5'd1 || rd_data !== 8'hA5) begin
                n_err++;
                $display("FAIL level_hold cyc %0d: count=%0d data=%h, expected 1/a5", i, fifo_count, rd_data);
            end
        end
        rx_status = 1'b0;
        rd_ready  = 1'b1;
        tick();
        rd_ready  = 1'b0;
        n_cmp++;
        if (fifo_count !== 5'd0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL edge_drain: count=%0d valid=%b, expected 0/0", fifo_count, rd_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        n_cmp++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill16: count=%0d ovf=%b, expected 16/0", fifo_count, overflow);
        end
        push_byte(8'h55);
        n_cmp++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drop: count=%0d ovf=%b, expected 16/1", fifo_count, overflow);
        end
        tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                n_err++;
                $display("FAIL ovf_read %0d: valid=%b data=%h, expected 1/%h", i, rd_valid, rd_data, 8'(i));
            end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_empty: valid=%b ovf=%b, expected 0/1 (0x55 must be absent)", rd_valid, overflow);
        end
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b, expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        tick();
        rx_data   = 8'h77;
        rx_status = 1'b1;
        rd_ready  = 1'b1;
        tick();
        rd_ready  = 1'b0;
        rx_status = 1'b0;
        n_cmp++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d ovf=%b, expected 16/0", fifo_count, overflow);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = m_q[0];
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                n_err++;
                $display("FAIL wrap_read %0d: valid=%b data=%h, expected 1/%h", i, rd_valid, rd_data, exp);
            end
            if (i == 15) begin
                n_cmp++;
                if (rd_data !== 8'h77) begin
                    n_err++;
                    $display("FAIL last_is_77: data=%h, expected 77", rd_data);
                end
            end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 5'd0) begin
            n_err++;
            $display("FAIL wrap_empty: count=%0d, expected 0", fifo_count);
        end
    endtask

    task automatic test_idle();
        rx_status = 1'b0;
        tick();
        rx_data   = 8'h42;
        rx_status = 1'b1;
        tick();
        for (int k = 1; k <= IDLE; k++) begin
            tick();
            if (k >= 600) begin
                n_cmp++;
                if (idle !== (k >= IDLE)) begin
                    n_err++;
                    $display("FAIL idle_timer k=%0d: idle=%b, expected %b", k, idle, (k >= IDLE));
                end
            end
        end
        rx_status = 1'b0;
        tick();
        n_cmp++;
        if (idle !== 1'b1) begin
            n_err++;
            $display("FAIL idle_saturate: idle=%b, expected 1", idle);
        end
        rx_data   = 8'h43;
        rx_status = 1'b1;
        tick();
        n_cmp++;
        if (idle !== 1'b0 || fifo_count !== 5'd2) begin
            n_err++;
            $display("FAIL idle_push: idle=%b count=%0d, expected 0/2", idle, fifo_count);
        end
        rx_status = 1'b0;
        rd_ready  = 1'b1;
        tick();
        tick();
        rd_ready  = 1'b0;
        n_cmp++;
        if (idle !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_drain: idle=%b valid=%b, expected 0/0", idle, rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 17; i++) push_byte(8'(8'h80 + i));
        rd_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rd_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 5'd5 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: count=%0d ovf=%b, expected 5/1", fifo_count, overflow);
        end
        rx_data   = 8'hEE;
        rx_status = 1'b1;
        reset     = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (fifo_count !== 5'd0 || overflow !== 1'b0 || idle !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: count=%0d ovf=%b idle=%b valid=%b, expected 0/0/0/0",
                     fifo_count, overflow, idle, rd_valid);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (fifo_count !== 5'd0) begin
            n_err++;
            $display("FAIL post_reset_level: count=%0d, expected 0", fifo_count);
        end
        rx_status = 1'b0;
        tick();
        rx_data   = 8'h3C;
        rx_status = 1'b1;
        tick();
        n_cmp++;
        if (fifo_count !== 5'd1 || rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
            n_err++;
            $display("FAIL post_reset_push: count=%0d valid=%b data=%h, expected 1/1/3c", fifo_count, rd_valid, rd_data);
        end
    endtask

    task automatic test_random();
        logic [4:0] exp_cnt;
        logic       exp_idle;
        for (int i = 0; i < 3000; i++) begin
            if (rx_status == 1'b0) begin
                if ($urandom_range(0, 1) == 0) begin
                    rx_data   = 8'($urandom);
                    rx_status = 1'b1;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                rx_status = 1'b0;
            end
            rd_ready  = (i < 1500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            ovf_clear = ($urandom_range(0, 49) == 0);
            tick();
            exp_cnt  = 5'(m_q.size());
            exp_idle = (m_age == IDLE) && (m_q.size() > 0);
            n_cmp++;
            if (fifo_count !== exp_cnt || rd_valid !== (exp_cnt != 0) || overflow !== m_ovf || idle !== exp_idle
                || (exp_cnt != 0 && rd_data !== m_q[0])) begin
                n_err++;
                $display("FAIL random cyc %0d: count=%0d valid=%b ovf=%b idle=%b data=%h, expected %0d/%b/%b/%b/%h",
                         i, fifo_count, rd_valid, overflow, idle, rd_data,
                         exp_cnt, (exp_cnt != 0), m_ovf, exp_idle, (exp_cnt != 0) ? m_q[0] : 8'h00);
            end
        end
        rd_ready  = 1'b0;
        ovf_clear = 1'b0;
        rx_status = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_hold();
        test_overflow();
        test_full_push_pop();
        test_idle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
